ring_router_buffered: RTL and testbench

//   Parametrised successor of the ring router: one node of the bidirectional NoC ring with

---
 rtl/ring_router_buffered.sv | 188 ++++++++++++++++++
 tb/tb_ring_router_buffered.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ring_router_buffered.sv
// One node of a bidirectional NoC ring: cw, ccw and local PE ports, each input
// buffered by a DEPTH-entry FIFO, each output driven by a one-entry register fed
// through a 2-way round-robin arbiter.
module ring_router_buffered #(
    parameter int unsigned WIDTH   = 64,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned HOP_LSB = 48,
    parameter int unsigned HOP_W   = 8,
    parameter int unsigned DIR_BIT = 62
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cwsi,
    output logic             cwri,
    input  logic [WIDTH-1:0] cwdi,
    input  logic             ccwsi,
    output logic             ccwri,
    input  logic [WIDTH-1:0] ccwdi,
    input  logic             pesi,
    output logic             peri,
    input  logic [WIDTH-1:0] pedi,
    output logic             cwso,
    input  logic             cwro,
    output logic [WIDTH-1:0] cwdo,
    output logic             ccwso,
    input  logic             ccwro,
    output logic [WIDTH-1:0] ccwdo,
    output logic             peso,
    input  logic             pero,
    output logic [WIDTH-1:0] pedo
);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] Full = CntW'(DEPTH);

    // Inputs and outputs are both indexed 0 = cw, 1 = ccw, 2 = pe.
    logic [2:0]       in_v, in_r, push, pop, hv;
    logic [WIDTH-1:0] in_d [3];
    logic [WIDTH-1:0] head [3];
    logic [WIDTH-1:0] mem_q [3][DEPTH];
    logic [PtrW-1:0]  wptr_q [3];
    logic [PtrW-1:0]  rptr_q [3];
    logic [CntW-1:0]  cnt_q [3];
    logic [CntW-1:0]  cnt_d [3];

    // Per output: requester a is ring traffic, requester b is the other source.
    logic [2:0]       ro, req_a, req_b, gnt_a, gnt_b, ld;
    logic [WIDTH-1:0] dat_a [3];
    logic [WIDTH-1:0] dat_b [3];
    logic [2:0]       ov_q, ov_d, ptr_q, ptr_d;
    logic [WIDTH-1:0] od_q [3];
    logic [WIDTH-1:0] od_d [3];

    logic [HOP_W-1:0] hop_cw, hop_ccw;
    logic [WIDTH-1:0] fwd_cw, fwd_ccw;

    assign in_v    = {pesi, ccwsi, cwsi};
    assign in_d[0] = cwdi;
    assign in_d[1] = ccwdi;
    assign in_d[2] = pedi;
    assign ro      = {pero, ccwro, cwro};

    assign cwri  = in_r[0];
    assign ccwri = in_r[1];
    assign peri  = in_r[2];
    assign cwso  = ov_q[0];
    assign ccwso = ov_q[1];
    assign peso  = ov_q[2];
    assign cwdo  = od_q[0];
    assign ccwdo = od_q[1];
    assign pedo  = od_q[2];

    // FIFO status: ready is held low while reset is asserted.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            in_r[i] = reset && (cnt_q[i] != Full);
            push[i] = in_v[i] && in_r[i];
            hv[i]   = (cnt_q[i] != '0);
            head[i] = mem_q[i][rptr_q[i]];
        end
    end

    // FIFO occupancy next state; push+pop together leaves the count unchanged.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = cnt_q[i];
            if (push[i] && !pop[i]) begin
                cnt_d[i] = cnt_q[i] + CntW'(1);
            end else if (!push[i] && pop[i]) begin
                cnt_d[i] = cnt_q[i] - CntW'(1);
            end
        end
    end

    // Route FIFO heads: ring flits continue with hop-1 or eject at hop 0.
    always_comb begin
        hop_cw  = head[0][HOP_LSB +: HOP_W];
        hop_ccw = head[1][HOP_LSB +: HOP_W];
        fwd_cw  = head[0];
        fwd_ccw = head[1];
        fwd_cw[HOP_LSB +: HOP_W]  = hop_cw - HOP_W'(1);
        fwd_ccw[HOP_LSB +: HOP_W] = hop_ccw - HOP_W'(1);
        req_a = {hv[0] && (hop_cw == '0), hv[1] && (hop_ccw != '0), hv[0] && (hop_cw != '0)};
        req_b = {hv[1] && (hop_ccw == '0), hv[2] && head[2][DIR_BIT], hv[2] && !head[2][DIR_BIT]};
        dat_a[0] = fwd_cw;
        dat_a[1] = fwd_ccw;
        dat_a[2] = head[0];
        dat_b[0] = head[2];
        dat_b[1] = head[2];
        dat_b[2] = head[1];
    end

    // Round-robin arbitration and output-register load; pointer 0 favours requester a.
    always_comb begin
        gnt_a = '0;
        gnt_b = '0;
        ld    = '0;
        ov_d  = ov_q;
        ptr_d = ptr_q;
        for (int o = 0; o < 3; o++) begin
            od_d[o]  = od_q[o];
            ld[o]    = !ov_q[o] || ro[o];
            gnt_a[o] = ld[o] && req_a[o] && (!req_b[o] || !ptr_q[o]);
            gnt_b[o] = ld[o] && req_b[o] && (!req_a[o] || ptr_q[o]);
            if (ld[o]) begin
                ov_d[o] = gnt_a[o] || gnt_b[o];
            end
            if (gnt_a[o]) begin
                od_d[o]  = dat_a[o];
                ptr_d[o] = 1'b1;
            end else if (gnt_b[o]) begin
                od_d[o]  = dat_b[o];
                ptr_d[o] = 1'b0;
            end
        end
        pop[0] = gnt_a[0] || gnt_a[2];
        pop[1] = gnt_a[1] || gnt_b[2];
        pop[2] = gnt_b[0] || gnt_b[1];
    end

    // FIFO storage; contents need no reset since occupancy gates their use.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (push[i]) begin
                mem_q[i][wptr_q[i]] <= in_d[i];
            end
        end
    end

    // FIFO pointers and counts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 3; i++) begin
                wptr_q[i] <= '0;
                rptr_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= cnt_d[i];
                if (push[i]) begin
                    wptr_q[i] <= wptr_q[i] + PtrW'(1);
                end
                if (pop[i]) begin
                    rptr_q[i] <= rptr_q[i] + PtrW'(1);
                end
            end
        end
    end

    // Output registers and arbiter pointers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ov_q  <= '0;
            ptr_q <= '0;
            for (int o = 0; o < 3; o++) begin
                od_q[o] <= '0;
            end
        end else begin
            ov_q  <= ov_d;
            ptr_q <= ptr_d;
            for (int o = 0; o < 3; o++) begin
                od_q[o] <= od_d[o];
            end
        end
    end

endmodule

// File: tb/tb_ring_router_buffered.sv
// Self-checking bench for ring_router_buffered: directed scenarios with literal
// expectations plus randomized traffic against a queue-based transaction model.
module tb_ring_router_buffered;
    localparam int unsigned WIDTH   = 64;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned HOP_LSB = 48;
    localparam int unsigned HOP_W   = 8;
    localparam int unsigned DIR_BIT = 62;

    logic             clk, reset;
    logic             cwsi, ccwsi, pesi, cwro, ccwro, pero;
    logic             cwri, ccwri, peri, cwso, ccwso, peso;
    logic [WIDTH-1:0] cwdi, ccwdi, pedi, cwdo, ccwdo, pedo;

    int checks   = 0;
    int failures = 0;

    // Model: input queues, output slots and the "favour second requester" flag.
    bit [63:0] q0[$], q1[$], q2[$];
    bit        mov [3];
    bit [63:0] mod [3];
    bit        mpref [3];

    ring_router_buffered #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .HOP_LSB(HOP_LSB), .HOP_W(HOP_W), .DIR_BIT(DIR_BIT)
    ) dut (
        .clk(clk), .reset(reset),
        .cwsi(cwsi), .cwri(cwri), .cwdi(cwdi),
        .ccwsi(ccwsi), .ccwri(ccwri), .ccwdi(ccwdi),
        .pesi(pesi), .peri(peri), .pedi(pedi),
        .cwso(cwso), .cwro(cwro), .cwdo(cwdo),
        .ccwso(ccwso), .ccwro(ccwro), .ccwdo(ccwdo),
        .peso(peso), .pero(pero), .pedo(pedo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input bit [63:0] act, input bit [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int qsize(int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic model_clear();
        q0.delete();
        q1.delete();
        q2.delete();
        for (int o = 0; o < 3; o++) begin
            mov[o]   = 1'b0;
            mod[o]   = '0;
            mpref[o] = 1'b0;
        end
    endtask

    // Advance the model across one rising edge using the currently driven inputs.
    task automatic model_step();
        bit [63:0]      hd [3];
        bit             hv [3];
        int             tgt [3];
        bit [63:0]      fwd [3];
        bit             acc [3];
        bit             pop [3];
        bit             si [3];
        bit [63:0]      di [3];
        bit             rdy [3];
        bit [HOP_W-1:0] hop;
        if (!reset) begin
            model_clear();
            return;
        end
        si  = '{cwsi, ccwsi, pesi};
        di  = '{cwdi, ccwdi, pedi};
        rdy = '{cwro, ccwro, pero};
        hd[0] = (q0.size() != 0) ? q0[0] : 64'd0;
        hd[1] = (q1.size() != 0) ? q1[0] : 64'd0;
        hd[2] = (q2.size() != 0) ? q2[0] : 64'd0;
        for (int k = 0; k < 3; k++) begin
            hv[k]  = qsize(k) != 0;
            acc[k] = si[k] && (qsize(k) < DEPTH);
            pop[k] = 1'b0;
            fwd[k] = hd[k];
        end
        for (int k = 0; k < 2; k++) begin
            hop = hd[k][HOP_LSB +: HOP_W];
            if (hop != 0) begin
                tgt[k] = k;
                fwd[k][HOP_LSB +: HOP_W] = hop - 1;
            end else begin
                tgt[k] = 2;
            end
        end
        tgt[2] = hd[2][DIR_BIT] ? 1 : 0;
        for (int o = 0; o < 3; o++) begin
            int ra   = (o == 2) ? 0 : o;
            int rb   = (o == 2) ? 1 : 2;
            int pick = -1;
            bit qa   = hv[ra] && (tgt[ra] == o);
            bit qb   = hv[rb] && (tgt[rb] == o);
            if (!mov[o] || rdy[o]) begin
                if (qa && qb) pick = mpref[o] ? rb : ra;
                else if (qa)  pick = ra;
                else if (qb)  pick = rb;
                mov[o] = (pick >= 0);
                if (pick >= 0) begin
                    mod[o]    = fwd[pick];
                    pop[pick] = 1'b1;
                    mpref[o]  = (pick == ra);
                end
            end
        end
        if (pop[0]) void'(q0.pop_front());
        if (pop[1]) void'(q1.pop_front());
        if (pop[2]) void'(q2.pop_front());
        if (acc[0]) q0.push_back(di[0]);
        if (acc[1]) q1.push_back(di[1]);
        if (acc[2]) q2.push_back(di[2]);
    endtask

    task automatic compare();
        bit        so_a [3];
        bit [63:0] do_a [3];
        bit        ri_a [3];
        so_a = '{cwso, ccwso, peso};
        do_a = '{cwdo, ccwdo, pedo};
        ri_a = '{cwri, ccwri, peri};
        for (int o = 0; o < 3; o++) begin
            chk($sformatf("so[%0d]", o), 64'(so_a[o]), 64'(mov[o]));
            if (mov[o]) chk($sformatf("do[%0d]", o), do_a[o], mod[o]);
            chk($sformatf("ri[%0d]", o), 64'(ri_a[o]), 64'(reset && (qsize(o) < DEPTH)));
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic idle_inputs();
        cwsi = 0; ccwsi = 0; pesi = 0;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        model_clear();
        #1;
        compare();
        tick();
        tick();
        reset = 1'b1;
        #1;
        compare();
    endtask

    function automatic bit [63:0] rnd_flit();
        bit [63:0] f;
        f = {$urandom, $urandom};
        f[HOP_LSB +: HOP_W] = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom_range(0, 3));
        return f;
    endfunction

    initial begin
        reset = 1'b1;
        idle_inputs();
        cwdi = '0; ccwdi = '0; pedi = '0;
        cwro = 1; ccwro = 1; pero = 1;
        model_clear();
        #2 reset = 1'b0;
        #1;
        chk("rst_cwri", 64'(cwri), 64'd0);
        chk("rst_cwso", 64'(cwso), 64'd0);
        chk("rst_pedo", pedo, 64'd0);
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("rel_cwri", 64'(cwri), 64'd1);
        chk("rel_peri", 64'(peri), 64'd1);
        compare();

        // cw through flit, hop 3 -> 2
        cwsi = 1; cwdi = 64'h1203_4567_89AB_CDEF;
        tick();
        idle_inputs();
        chk("t1_early_cwso", 64'(cwso), 64'd0);
        tick();
        chk("t1_cwso", 64'(cwso), 64'd1);
        chk("t1_cwdo", cwdo, 64'h1202_4567_89AB_CDEF);
        tick();
        chk("t1_drained", 64'(cwso), 64'd0);

        // ccw flit with hop 0 ejects bit-exact
        ccwsi = 1; ccwdi = 64'h2A00_0000_0000_0055;
        tick();
        idle_inputs();
        tick();
        chk("t2_peso", 64'(peso), 64'd1);
        chk("t2_pedo", pedo, 64'h2A00_0000_0000_0055);
        chk("t2_ccwso", 64'(ccwso), 64'd0);
        tick();

        // PE injection in both directions, hops untouched
        pesi = 1; pedi = 64'h0005_0000_0000_0001;
        tick();
        pedi = 64'h4007_0000_0000_0002;
        tick();
        idle_inputs();
        chk("t3_cwdo", cwdo, 64'h0005_0000_0000_0001);
        tick();
        chk("t3_ccwso", 64'(ccwso), 64'd1);
        chk("t3_ccwdo", ccwdo, 64'h4007_0000_0000_0002);
        tick();

        // Backpressure: 4 in FIFO + 1 in output register, then drain in order
        cwro = 0;
        for (int i = 0; i < 5; i++) begin
            cwsi = 1; cwdi = {8'(8'h30 + i), 8'h05, 48'(i)};
            if (i == 4) chk("t4_ri_before_full", 64'(cwri), 64'd1);
            tick();
        end
        idle_inputs();
        chk("t4_cwri_full", 64'(cwri), 64'd0);
        cwro = 1;
        for (int i = 0; i < 5; i++) begin
            chk("t4_cwso", 64'(cwso), 64'd1);
            chk("t4_cwdo", cwdo, {8'(8'h30 + i), 8'h04, 48'(i)});
            tick();
        end
        chk("t4_empty", 64'(cwso), 64'd0);

        // Fairness between through and inject, starting with through
        pulse_reset();
        cwsi = 1; cwdi = 64'h1101_0000_0000_00AA;
        pesi = 1; pedi = 64'h2200_0000_0000_00BB;
        tick();
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t5_cwso", 64'(cwso), 64'd1);
            chk("t5_cwdo", cwdo, (i % 2 == 0) ? 64'h1100_0000_0000_00AA : 64'h2200_0000_0000_00BB);
        end

        // Reset with traffic in all FIFOs
        cwro = 0; ccwro = 0; pero = 0;
        ccwsi = 1; ccwdi = 64'h0003_0000_0000_0CC0;
        for (int i = 0; i < 3; i++) tick();
        idle_inputs();
        reset = 1'b0;
        model_clear();
        #1;
        chk("t6_cwso", 64'(cwso), 64'd0);
        chk("t6_ccwso", 64'(ccwso), 64'd0);
        chk("t6_peso", 64'(peso), 64'd0);
        chk("t6_cwri", 64'(cwri), 64'd0);
        chk("t6_ccwri", 64'(ccwri), 64'd0);
        chk("t6_peri", 64'(peri), 64'd0);
        chk("t6_cwdo", cwdo, 64'd0);
        tick();
        reset = 1'b1;
        cwro = 1; ccwro = 1; pero = 1;
        #1;
        chk("t6_rel_ri", 64'({cwri, ccwri, peri}), 64'h7);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t6_quiet", 64'({cwso, ccwso, peso}), 64'd0);
        end

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) pulse_reset();
            cwsi  = ($urandom_range(0, 3) != 0);
            ccwsi = ($urandom_range(0, 3) != 0);
            pesi  = ($urandom_range(0, 2) != 0);
            cwdi  = rnd_flit();
            ccwdi = rnd_flit();
            pedi  = rnd_flit();
            cwro  = ($urandom_range(0, 3) != 0);
            ccwro = ($urandom_range(0, 3) != 0);
            pero  = ($urandom_range(0, 4) != 0);
            tick();
        end
        idle_inputs();
        cwro = 1; ccwro = 1; pero = 1;
        for (int n = 0; n < 40; n++) tick();
        chk("final_drained", 64'({cwso, ccwso, peso}), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
